clock_mode_ctrl: RTL and testbench

//  Sequencer for the BCD time-of-day chain: a seconds counter (mod-60), a minutes counter (mod-60) and
//  the 24-hour counter. Divides the board clock to a 1 Hz tick and drives each counter's count enable.

---
 rtl/clock_ctrl_pkg.sv | 25 ++
 rtl/btn_edge_sync.sv | 38 +++
 rtl/clock_mode_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings for the time-of-day sequencer.
// The mode port carries these values directly, so the enum is tied to the localparams.
package clock_ctrl_pkg;

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = MODE_RUN,
    ST_SET_HR  = MODE_SET_HR,
    ST_SET_MIN = MODE_SET_MIN,
    ST_BAD     = 2'b11
  } mode_e;

  // RUN -> SET_HR -> SET_MIN -> RUN. The unused code also lands in RUN.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      ST_RUN:    return ST_SET_HR;
      ST_SET_HR: return ST_SET_MIN;
      default:   return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A pin edge shows up as a single-cycle pulse three clocks later.
module btn_edge_sync (
  input  logic clk,
  input  logic cr,
  input  logic btn,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = btn;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-of-day sequencer: 1 Hz prescaler, RUN/SET_HR/SET_MIN mode FSM driven by two buttons,
// registered count enables for the sec/min/hr counters and registered digit-blink outputs.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hr,
  output logic [1:0] mode,
  output logic       blink_hr,
  output logic       blink_min
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic mode_pulse;
  logic inc_pulse;

  btn_edge_sync u_mode_sync (
    .clk   (clk),
    .cr    (cr),
    .btn   (btn_mode),
    .pulse (mode_pulse)
  );

  btn_edge_sync u_inc_sync (
    .clk   (clk),
    .cr    (cr),
    .btn   (btn_inc),
    .pulse (inc_pulse)
  );

  mode_e           mode_q, mode_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic            en_sec_q, en_sec_d;
  logic            en_min_q, en_min_d;
  logic            en_hr_q, en_hr_d;
  logic            blink_hr_q, blink_hr_d;
  logic            blink_min_q, blink_min_d;
  logic            tick;
  logic            mode_change;

  always_comb begin
    tick     = (pre_q == PRE_TC);
    pre_d    = tick ? '0 : pre_q + PW'(1);
    mode_d   = mode_q;
    en_sec_d = 1'b0;
    en_min_d = 1'b0;
    en_hr_d  = 1'b0;

    // Enables always use the pre-transition mode; a mode change swallows a same-cycle inc.
    case (mode_q)
      ST_RUN: begin
        en_sec_d = tick;
        en_min_d = tick & sec_carry;
        en_hr_d  = tick & sec_carry & min_carry;
      end
      ST_SET_HR: begin
        en_hr_d = inc_pulse & ~mode_pulse;
      end
      ST_SET_MIN: begin
        en_min_d = inc_pulse & ~mode_pulse;
        if (mode_pulse) pre_d = '0;
      end
      default: ;
    endcase

    if (mode_pulse || (mode_q == ST_BAD)) mode_d = next_mode(mode_q);
    mode_change = (mode_d != mode_q);

    // Restarting the blink divider on a mode change keeps the new digits lit for a full phase.
    if (mode_change) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BLINK_TC) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
    end

    blink_hr_d  = (mode_d == ST_SET_HR) & phase_d;
    blink_min_d = (mode_d == ST_SET_MIN) & phase_d;
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      mode_q      <= ST_RUN;
      pre_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      en_sec_q    <= 1'b0;
      en_min_q    <= 1'b0;
      en_hr_q     <= 1'b0;
      blink_hr_q  <= 1'b0;
      blink_min_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      en_sec_q    <= en_sec_d;
      en_min_q    <= en_min_d;
      en_hr_q     <= en_hr_d;
      blink_hr_q  <= blink_hr_d;
      blink_min_q <= blink_min_d;
    end
  end

  assign en_sec    = en_sec_q;
  assign en_min    = en_min_q;
  assign en_hr     = en_hr_q;
  assign mode      = mode_q;
  assign blink_hr  = blink_hr_q;
  assign blink_min = blink_min_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl with small divider values and behavioural sec/min/hr counters attached.
// A cycle-count reference model predicts every output; directed scenarios pin the model with literals.
module tb_clock_mode_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int BLINK_DIV = 3;

  logic       clk = 1'b0;
  logic       cr = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_carry, min_carry;
  logic       en_sec, en_min, en_hr;
  logic [1:0] mode;
  logic       blink_hr, blink_min;

  clock_mode_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
    .clk       (clk),
    .cr        (cr),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sec_carry (sec_carry),
    .min_carry (min_carry),
    .en_sec    (en_sec),
    .en_min    (en_min),
    .en_hr     (en_hr),
    .mode      (mode),
    .blink_hr  (blink_hr),
    .blink_min (blink_min)
  );

  always #5 clk = ~clk;

  // Attached time-of-day counters (plain integers), with a one-shot preload.
  int   sec = 0, min = 0, hr = 0;
  logic load_req = 1'b0;
  int   load_h = 0, load_m = 0, load_s = 0;

  assign sec_carry = (sec == 59);
  assign min_carry = (min == 59);

  // Reference model: edge count since reset, anchors for the 1 Hz phase and blink phase,
  // and a short history of sampled pin levels giving the 3-clock button pulse.
  int   k = 0, anchor = 0, banchor = 0, m_mode = 0;
  bit   mh [4];
  bit   ih [4];
  bit   mp, ip, tick, phase;
  bit   exp_sec, exp_min, exp_hr, exp_bhr, exp_bmin;
  int   exp_mode = 0;
  bit   model_valid = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      sec <= load_s;
      min <= load_m;
      hr  <= load_h;
    end else begin
      if (en_sec) sec <= (sec + 1) % 60;
      if (en_min) min <= (min + 1) % 60;
      if (en_hr)  hr  <= (hr + 1) % 24;
    end

    if (!cr) begin
      k = 0; anchor = 0; banchor = 0; m_mode = 0;
      for (int i = 0; i < 4; i++) begin mh[i] = 1'b0; ih[i] = 1'b0; end
      model_valid = 1'b0;
    end else begin
      mp = mh[2] && !mh[3];
      ip = ih[2] && !ih[3];
      k++;
      tick = (((k - 1 - anchor) % CLK_HZ) == CLK_HZ - 1);
      exp_sec = (m_mode == 0) && tick;
      exp_min = ((m_mode == 0) && tick && (sec == 59)) || ((m_mode == 2) && ip && !mp);
      exp_hr  = ((m_mode == 0) && tick && (sec == 59) && (min == 59)) || ((m_mode == 1) && ip && !mp);
      if (mp) begin
        if (m_mode == 2) anchor = k;
        m_mode  = (m_mode + 1) % 3;
        banchor = k;
      end
      exp_mode = m_mode;
      phase    = (((k - banchor) / BLINK_DIV) % 2) == 1;
      exp_bhr  = (m_mode == 1) && phase;
      exp_bmin = (m_mode == 2) && phase;
      for (int i = 3; i > 0; i--) begin mh[i] = mh[i-1]; ih[i] = ih[i-1]; end
      mh[0] = btn_mode;
      ih[0] = btn_inc;
      model_valid = 1'b1;
    end
  end

  int checks = 0, errors = 0;
  int cnt_sec = 0, cnt_min = 0, cnt_hr = 0;
  int n, last_chg, bmin_cnt, hr_before;
  logic prev_b;

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("en_sec", int'(en_sec), int'(exp_sec));
    checkValue("en_min", int'(en_min), int'(exp_min));
    checkValue("en_hr", int'(en_hr), int'(exp_hr));
    checkValue("mode", int'(mode), exp_mode);
    checkValue("blink_hr", int'(blink_hr), int'(exp_bhr));
    checkValue("blink_min", int'(blink_min), int'(exp_bmin));
  endtask

  task automatic checkReset();
    checkValue("rst_en_sec", int'(en_sec), 0);
    checkValue("rst_en_min", int'(en_min), 0);
    checkValue("rst_en_hr", int'(en_hr), 0);
    checkValue("rst_mode", int'(mode), 0);
    checkValue("rst_blink_hr", int'(blink_hr), 0);
    checkValue("rst_blink_min", int'(blink_min), 0);
  endtask

  // Advance to the next falling edge, check every output, and tally enable pulses.
  task automatic stepCycle();
    @(negedge clk);
    if (!cr) checkReset();
    else if (model_valid) checkOutput();
    if (en_sec) cnt_sec++;
    if (en_min) cnt_min++;
    if (en_hr)  cnt_hr++;
  endtask

  task automatic clearCounts();
    cnt_sec = 0; cnt_min = 0; cnt_hr = 0;
  endtask

  task automatic loadTime(input int h, input int m, input int s);
    load_h = h; load_m = m; load_s = s;
    load_req = 1'b1;
    stepCycle();
    load_req = 1'b0;
  endtask

  task automatic pressBtn(input bit is_mode);
    if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    stepCycle();
    stepCycle();
    if (is_mode) btn_mode = 1'b0; else btn_inc = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle();
  endtask

  // Counts cycles until en_sec is seen; an expired bound is reported as a failure.
  task automatic waitEnSec(input string name, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      stepCycle();
      if (en_sec) begin cycles = i; break; end
    end
    if (cycles < 0) checkValue({name, "_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
    if ($urandom_range(0, 5) == 0)  btn_inc  = ~btn_inc;
    if ($urandom_range(0, 149) == 0) begin
      load_h = int'($urandom_range(0, 23));
      load_m = int'($urandom_range(57, 59));
      load_s = int'($urandom_range(55, 59));
      load_req = 1'b1;
    end
    if ($urandom_range(0, 399) == 0) begin
      #2 cr = 1'b0;
      for (int i = 0; i < 3; i++) stepCycle();
      cr = 1'b1;
    end
  endtask

  initial begin
    // Reset held with buttons wiggling; release then expect the first tick after a full second.
    for (int i = 0; i < 6; i++) begin
      btn_mode = i[0];
      btn_inc  = ~i[0];
      stepCycle();
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    stepCycle();
    cr = 1'b1;
    waitEnSec("first_tick", 20, n);
    checkValue("first_tick_latency", n, 10);

    // 23:59:59 rolls to 00:00:00 in one step.
    loadTime(23, 59, 59);
    waitEnSec("rollover", 12, n);
    checkValue("rollover_en_min", int'(en_min), 1);
    checkValue("rollover_en_hr", int'(en_hr), 1);
    stepCycle();
    checkValue("rollover_hms", hr * 10000 + min * 100 + sec, 0);

    // SET_HR: time frozen, five increments, blink period.
    clearCounts();
    pressBtn(1'b1);
    checkValue("set_hr_mode", int'(mode), 1);
    last_chg = -1; prev_b = blink_hr; bmin_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (blink_min) bmin_cnt++;
      if (blink_hr != prev_b) begin
        if (last_chg >= 0) checkValue("blink_hr_period", i - last_chg, 3);
        last_chg = i;
        prev_b = blink_hr;
      end
    end
    checkValue("set_hr_no_en_sec", cnt_sec, 0);
    checkValue("set_hr_blink_min", bmin_cnt, 0);
    hr_before = hr;
    clearCounts();
    for (int i = 0; i < 5; i++) pressBtn(1'b0);
    checkValue("set_hr_pulses", cnt_hr, 5);
    checkValue("set_hr_hour", hr, (hr_before + 5) % 24);

    // SET_MIN at 59 wraps without touching hours; leaving restarts the second.
    pressBtn(1'b1);
    checkValue("set_min_mode", int'(mode), 2);
    loadTime(5, 59, 0);
    clearCounts();
    pressBtn(1'b0);
    checkValue("set_min_pulses", cnt_min, 1);
    checkValue("set_min_no_hr", cnt_hr, 0);
    checkValue("set_min_wrap", min, 0);
    checkValue("set_min_hour", hr, 5);
    btn_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (i == 1) btn_mode = 1'b0;
      if (mode == 2'b00) break;
    end
    checkValue("back_to_run", int'(mode), 0);
    btn_mode = 1'b0;
    waitEnSec("run_restart", 20, n);
    checkValue("run_restart_latency", n, 10);

    // Mode and inc edges together in SET_HR, then a held inc in SET_MIN.
    pressBtn(1'b1);
    checkValue("coll_pre_mode", int'(mode), 1);
    clearCounts();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    stepCycle();
    stepCycle();
    btn_mode = 1'b0;
    for (int i = 0; i < 6; i++) stepCycle();
    btn_inc = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkValue("coll_mode", int'(mode), 2);
    checkValue("coll_no_hr", cnt_hr, 0);
    checkValue("coll_no_min", cnt_min, 0);
    clearCounts();
    btn_inc = 1'b1;
    for (int i = 0; i < 50; i++) stepCycle();
    btn_inc = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle();
    checkValue("held_inc_pulses", cnt_min, 1);

    // Async reset while an inc pulse is still in the synchronizer.
    btn_inc = 1'b1;
    stepCycle();
    stepCycle();
    #2 cr = 1'b0;
    btn_inc = 1'b0;
    #1;
    checkValue("abort_mode", int'(mode), 0);
    checkValue("abort_en_min", int'(en_min), 0);
    clearCounts();
    for (int i = 0; i < 4; i++) stepCycle();
    cr = 1'b1;
    for (int i = 0; i < 12; i++) stepCycle();
    checkValue("abort_no_en_min", cnt_min, 0);
    checkValue("abort_mode_after", int'(mode), 0);

    // Randomized buttons, preloads near rollover, and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      load_req = 1'b0;
      applyStimulus();
      stepCycle();
    end
    load_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
